tug_of_war_field: RTL and testbench

Parametrised tug-of-war playfield that replaces per-light cells with a single N-light controller. It tracks the lit position, advances it one step per key press (rising edge), detects a win when the light is pushed off either end, keeps per-player round scores and holds the result until a restart. It sits between the synchronised key inputs and the LED driver in the lab game top level.

---
 rtl/tug_of_war_field.sv | 125 ++++++++++++
 tb/tb_tug_of_war_field.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tug_of_war_field.sv
// Single-controller tug-of-war playfield: tracks the lit position, turns key
// rising edges into one-step moves, detects wins off either end and keeps scores.
module tug_of_war_field #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L,
  input  logic                  R,
  input  logic                  restart,
  output logic [NUM_LIGHTS-1:0] lightOn,
  output logic [1:0]            winner,
  output logic [SCORE_W-1:0]    scoreL,
  output logic [SCORE_W-1:0]    scoreR
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam logic [PW-1:0] CENTRE = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] LAST   = PW'(NUM_LIGHTS - 1);
  localparam logic [PW-1:0] FIRST  = PW'(0);

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    WIN_L = 2'b10,
    WIN_R = 2'b01
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic [SCORE_W-1:0]   scoreL_q, scoreL_d;
  logic [SCORE_W-1:0]   scoreR_q, scoreR_d;
  logic                 L_q, R_q;
  logic                 lp_s, rp_s;

  // Increment that sticks at all ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    if (v == {SCORE_W{1'b1}}) begin
      return v;
    end else begin
      return v + SCORE_W'(1);
    end
  endfunction

  assign lp_s = L & ~L_q;
  assign rp_s = R & ~R_q;

  // State, position, score and key-history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= PLAY;
      pos_q    <= CENTRE;
      scoreL_q <= {SCORE_W{1'b0}};
      scoreR_q <= {SCORE_W{1'b0}};
      L_q      <= 1'b0;
      R_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      scoreL_q <= scoreL_d;
      scoreR_q <= scoreR_d;
      L_q      <= L;
      R_q      <= R;
    end
  end

  // Next-state logic; restart outranks any press in the same cycle.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    scoreL_d = scoreL_q;
    scoreR_d = scoreR_q;
    case (state_q)
      PLAY: begin
        if (restart) begin
          pos_d = CENTRE;
        end else if (lp_s && !rp_s) begin
          if (pos_q == LAST) begin
            state_d  = WIN_L;
            scoreL_d = sat_inc(scoreL_q);
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end else if (rp_s && !lp_s) begin
          if (pos_q == FIRST) begin
            state_d  = WIN_R;
            scoreR_d = sat_inc(scoreR_q);
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end else begin
          pos_d = pos_q;
        end
      end
      WIN_L, WIN_R: begin
        if (restart) begin
          state_d = PLAY;
          pos_d   = CENTRE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = PLAY;
        pos_d   = CENTRE;
      end
    endcase
  end

  // Output decode from registers only.
  always_comb begin
    lightOn = {NUM_LIGHTS{1'b0}};
    winner  = 2'b00;
    case (state_q)
      PLAY:    lightOn = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << pos_q;
      WIN_L:   winner  = 2'b10;
      WIN_R:   winner  = 2'b01;
      default: winner  = 2'b00;
    endcase
  end

  assign scoreL = scoreL_q;
  assign scoreR = scoreR_q;

endmodule

// File: tb/tb_tug_of_war_field.sv
// Directed bench for tug_of_war_field: a behavioural game model checked every
// negedge against two instances (SCORE_W = 3 and SCORE_W = 2), plus literal pins.
module tb_tug_of_war_field;

  logic clk = 1'b0;
  logic reset, L, R, restart;
  logic [8:0] light3, light2;
  logic [1:0] win3, win2;
  logic [2:0] sl3, sr3;
  logic [1:0] sl2, sr2;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  // Game model: position as integer, winner 0 none / 1 left / 2 right.
  int m_pos, m_win, m_sl3, m_sr3, m_sl2, m_sr2;
  bit m_pl, m_pr;

  tug_of_war_field #(.NUM_LIGHTS(9), .SCORE_W(3)) u3 (
    .clk(clk), .reset(reset), .L(L), .R(R), .restart(restart),
    .lightOn(light3), .winner(win3), .scoreL(sl3), .scoreR(sr3)
  );

  tug_of_war_field #(.NUM_LIGHTS(9), .SCORE_W(2)) u2 (
    .clk(clk), .reset(reset), .L(L), .R(R), .restart(restart),
    .lightOn(light2), .winner(win2), .scoreL(sl2), .scoreR(sr2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_light();
    if (m_win == 0) return 1 << m_pos;
    else return 0;
  endfunction

  function automatic int exp_winner();
    if (m_win == 1) return 2;
    else if (m_win == 2) return 1;
    else return 0;
  endfunction

  task automatic model_reset();
    m_pos = 4; m_win = 0;
    m_sl3 = 0; m_sr3 = 0; m_sl2 = 0; m_sr2 = 0;
    m_pl = 1'b0; m_pr = 1'b0;
  endtask

  // One clock: apply inputs, advance model with the edge, settle past the edge.
  task automatic cyc(input bit l, input bit r, input bit rs);
    bit lp, rp;
    L = l; R = r; restart = rs;
    lp = l && !m_pl;
    rp = r && !m_pr;
    @(posedge clk);
    if (m_win == 0) begin
      if (rs) m_pos = 4;
      else if (lp && !rp) begin
        if (m_pos == 8) begin
          m_win = 1;
          m_sl3 = (m_sl3 < 7) ? m_sl3 + 1 : 7;
          m_sl2 = (m_sl2 < 3) ? m_sl2 + 1 : 3;
        end else m_pos = m_pos + 1;
      end else if (rp && !lp) begin
        if (m_pos == 0) begin
          m_win = 2;
          m_sr3 = (m_sr3 < 7) ? m_sr3 + 1 : 7;
          m_sr2 = (m_sr2 < 3) ? m_sr2 + 1 : 3;
        end else m_pos = m_pos - 1;
      end
    end else if (rs) begin
      m_win = 0;
      m_pos = 4;
    end
    m_pl = l; m_pr = r;
    #1;
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("light3", int'(light3), exp_light());
      chk("winner3", int'(win3), exp_winner());
      chk("scoreL3", int'(sl3), m_sl3);
      chk("scoreR3", int'(sr3), m_sr3);
      chk("light2", int'(light2), exp_light());
      chk("winner2", int'(win2), exp_winner());
      chk("scoreL2", int'(sl2), m_sl2);
      chk("scoreR2", int'(sr2), m_sr2);
    end
  end

  initial begin
    L = 1'b0; R = 1'b0; restart = 1'b0; reset = 1'b1;
    model_reset();
    #3;
    reset = 1'b0;
    #1;
    chk("reset_light", int'(light3), 9'b000010000);
    chk("reset_winner", int'(win3), 2'b00);
    chk("reset_scores", int'({sl3, sr3}), 0);
    @(negedge clk);
    reset = 1'b1;
    run_cmp = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Held L moves exactly once, then one R press returns to centre.
    cyc(1'b1, 1'b0, 1'b0);
    chk("hold_first", int'(light3), 9'b000100000);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    chk("hold_after", int'(light3), 9'b000100000);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("r_back", int'(light3), 9'b000010000);
    cyc(1'b0, 1'b0, 1'b0);

    // Simultaneous presses cancel; releasing R with L held gives no move.
    cyc(1'b1, 1'b1, 1'b0);
    chk("both", int'(light3), 9'b000010000);
    cyc(1'b1, 1'b0, 1'b0);
    chk("l_still_held", int'(light3), 9'b000010000);
    cyc(1'b0, 1'b0, 1'b0);

    // Five L presses win for the left player.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i == 3) chk("l_edge", int'(light3), 9'b100000000);
      if (i == 4) begin
        chk("win_light", int'(light3), 0);
        chk("win_winner", int'(win3), 2'b10);
        chk("win_scoreL", int'(sl3), 1);
      end
      cyc(1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("win_hold", int'(win3), 2'b10);
    cyc(1'b0, 1'b0, 1'b1);
    chk("restart_light", int'(light3), 9'b000010000);
    chk("restart_winner", int'(win3), 2'b00);
    chk("restart_scoreL", int'(sl3), 1);
    cyc(1'b0, 1'b0, 1'b0);

    // Reach pos 2, then restart together with an R press.
    repeat (2) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("pos2", int'(light3), 9'b000000100);
    cyc(1'b0, 1'b1, 1'b1);
    chk("restart_override", int'(light3), 9'b000010000);
    cyc(1'b0, 1'b1, 1'b0);
    chk("held_across", int'(light3), 9'b000010000);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("repress", int'(light3), 9'b000001000);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("l_across_restart", int'(light3), 9'b000010000);
    cyc(1'b0, 1'b0, 1'b0);

    // Eight right wins: SCORE_W=2 pins at 3, SCORE_W=3 pins at 7.
    for (int w = 1; w <= 8; w++) begin
      repeat (5) begin
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
      end
      chk("rwin_winner", int'(win3), 2'b01);
      if (w >= 3) chk("sat2", int'(sr2), 3);
      if (w >= 7) chk("sat3", int'(sr3), 7);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-round, then a key held through release.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("areset_light", int'(light3), 9'b000010000);
    chk("areset_sr2", int'(sr2), 0);
    chk("areset_sl3", int'(sl3), 0);
    L = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    chk("press_at_release", int'(light3), 9'b000100000);
    cyc(1'b0, 1'b0, 1'b0);

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
